// File: rtl/pulse_div_chain.sv
// Cascade of STAGES modulo-MODULUS pulse counters with per-stage one-cycle carry pulses.
// Optional parallel load enabled by defining PULSE_DIV_LOAD_EN.

module pulse_div_stage #(
   parameter int MODULUS = 10,
   parameter int CW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   input  logic          adv,
   input  logic          down,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          carry
);
   localparam logic [CW-1:0] TOP = CW'(MODULUS - 1);
   localparam logic [CW-1:0] ONE = CW'(1);

   assign wrap = down ? (count == '0) : (count == TOP);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
         carry <= 1'b0;
      end else if (load) begin
         // out-of-range load fields saturate so the count stays a legal digit
         count <= (load_value > TOP) ? TOP : load_value;
         carry <= 1'b0;
      end else begin
         carry <= adv & wrap;
         if (adv) begin
            if (wrap) count <= down ? TOP : '0;
            else      count <= down ? count - ONE : count + ONE;
         end
      end
   end
endmodule

module pulse_div_chain #(
   parameter int STAGES  = 3,
   parameter int MODULUS = 10,
   parameter int CW      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_time,
   input  logic                 pause,
   input  logic                 down,
   input  logic                 pulse_in,
`ifdef PULSE_DIV_LOAD_EN
   input  logic                 load,
   input  logic [STAGES*CW-1:0] load_value,
`endif
   output logic [STAGES*CW-1:0] count_flat,
   output logic [STAGES-1:0]    carry_out,
   output logic                 pulse_out,
   output logic                 all_zero
);
   logic                 ld;
   logic [STAGES*CW-1:0] ld_val;
   logic [STAGES-1:0]    adv;
   logic [STAGES-1:0]    wrap;

`ifdef PULSE_DIV_LOAD_EN
   assign ld     = load;
   assign ld_val = load_value;
`else
   assign ld     = 1'b0;
   assign ld_val = '0;
`endif

   // ripple enable: a stage advances only when every lower stage wraps this cycle
   always_comb begin
      adv    = '0;
      adv[0] = pulse_in & ~pause;
      for (int k = 1; k < STAGES; k++)
         adv[k] = adv[k-1] & wrap[k-1];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pulse_div_stage #(.MODULUS(MODULUS), .CW(CW)) u_stage (
         .clk        (clk),
         .rst        (rst),
         .clear      (clear_time),
         .load       (ld),
         .load_value (ld_val[k*CW +: CW]),
         .adv        (adv[k]),
         .down       (down),
         .count      (count_flat[k*CW +: CW]),
         .wrap       (wrap[k]),
         .carry      (carry_out[k])
      );
   end

   assign pulse_out = carry_out[STAGES-1];
   assign all_zero  = (count_flat == '0);
endmodule

// File: tb/tb_pulse_div_chain.sv
// Scoreboard bench for pulse_div_chain (3 decimal digits): stimulus pushes expectations, monitor checks.

module tb_pulse_div_chain;
   logic        clk;
   logic        rst, clear_time, pause, down, pulse_in;
   logic [11:0] count_flat;
   logic [2:0]  carry_out;
   logic        pulse_out, all_zero;
`ifdef PULSE_DIV_LOAD_EN
   logic        load;
   logic [11:0] load_value;
`endif

   pulse_div_chain #(.STAGES(3), .MODULUS(10), .CW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear_time (clear_time),
      .pause      (pause),
      .down       (down),
      .pulse_in   (pulse_in),
`ifdef PULSE_DIV_LOAD_EN
      .load       (load),
      .load_value (load_value),
`endif
      .count_flat (count_flat),
      .carry_out  (carry_out),
      .pulse_out  (pulse_out),
      .all_zero   (all_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [11:0] cnt;
      logic [2:0]  car;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   misc    = 0;
   int   po_seen = 0;
   int   m_v     = 0;   // model value as a plain integer 0..999

   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         vectors++;
         if (count_flat !== mon_e.cnt || carry_out !== mon_e.car ||
             pulse_out !== mon_e.car[2] || all_zero !== (mon_e.cnt == 12'h000)) begin
            misc++;
            $display("FAIL %s: got cnt=%h car=%b po=%b az=%b, expected cnt=%h car=%b po=%b az=%b",
                     mon_e.name, count_flat, carry_out, pulse_out, all_zero,
                     mon_e.cnt, mon_e.car, mon_e.car[2], (mon_e.cnt == 12'h000));
         end
         if (pulse_out === 1'b1) po_seen++;
      end
   end

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int clamp9(input logic [3:0] f);
      return (f > 4'd9) ? 9 : int'(f);
   endfunction

   // one clock of stimulus; hand=1 replaces the model expectation with a hand-computed one
   task automatic step(input string nm, input bit r, input bit c, input bit pse, input bit d,
                       input bit pin, input bit ld, input logic [11:0] lv,
                       input bit hand, input logic [11:0] hcnt, input logic [2:0] hcar);
      exp_t        e;
      logic [2:0]  mc;
      int          pw;
      rst = r; clear_time = c; pause = pse; down = d; pulse_in = pin;
`ifdef PULSE_DIV_LOAD_EN
      load = ld; load_value = lv;
`endif
      mc = 3'b000;
      if (r || c) m_v = 0;
      else if (ld) m_v = 100 * clamp9(lv[11:8]) + 10 * clamp9(lv[7:4]) + clamp9(lv[3:0]);
      else if (pin && !pse) begin
         pw = 1;
         for (int k = 0; k < 3; k++) begin
            pw = pw * 10;
            mc[k] = d ? (m_v % pw == 0) : (m_v % pw == pw - 1);
         end
         m_v = d ? (m_v + 999) % 1000 : (m_v + 1) % 1000;
      end
      e.name = nm;
      e.cnt  = hand ? hcnt : to_bcd(m_v);
      e.car  = hand ? hcar : mc;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse(input string nm, input bit d);
      step(nm, 0, 0, 0, d, 1, 0, 12'h000, 0, 12'h000, 3'b000);
   endtask

   task automatic chk(input string nm, input bit r, input bit c, input bit pse, input bit d,
                      input bit pin, input logic [11:0] hcnt, input logic [2:0] hcar);
      step(nm, r, c, pse, d, pin, 0, 12'h000, 1, hcnt, hcar);
   endtask

   int po0;

   initial begin
      // reset dominates a pulse
      chk("reset1", 1, 0, 0, 0, 1, 12'h000, 3'b000);
      chk("reset2", 1, 0, 0, 0, 1, 12'h000, 3'b000);
      chk("idle_after_reset", 0, 0, 0, 0, 0, 12'h000, 3'b000);

      for (int i = 1; i <= 9; i++) pulse("up_count", 0);
      chk("up_10th_carry", 0, 0, 0, 0, 1, 12'h010, 3'b001);
      chk("up_carry_drops", 0, 0, 0, 0, 0, 12'h010, 3'b000);

      for (int i = 0; i < 989; i++) pulse("run_to_999", 0);
      chk("at_999", 0, 0, 0, 0, 0, 12'h999, 3'b000);
      chk("full_wrap_up", 0, 0, 0, 0, 1, 12'h000, 3'b111);
      chk("full_wrap_drop", 0, 0, 0, 0, 0, 12'h000, 3'b000);

      po0 = po_seen;
      for (int i = 0; i < 1000; i++) pulse("thousand", 0);
      vectors++;
      if (po_seen - po0 != 1) begin
         misc++;
         $display("FAIL thousand_pulse_out: got %0d pulse_out events, expected 1", po_seen - po0);
      end

      chk("down_wrap", 0, 0, 0, 1, 1, 12'h999, 3'b111);
      chk("down_998", 0, 0, 0, 1, 1, 12'h998, 3'b000);
      chk("pause_hold", 0, 0, 1, 1, 1, 12'h998, 3'b000);
      chk("pause_hold2", 0, 0, 1, 0, 1, 12'h998, 3'b000);
      chk("up_to_999", 0, 0, 0, 0, 1, 12'h999, 3'b000);
      chk("down_back", 0, 0, 0, 1, 1, 12'h998, 3'b000);
      for (int i = 0; i < 489; i++) pulse("run_down", 1);
      chk("at_509", 0, 0, 0, 1, 0, 12'h509, 3'b000);
      chk("down_510_carry", 0, 0, 0, 1, 1, 12'h508, 3'b000);
      chk("up_509", 0, 0, 0, 0, 1, 12'h509, 3'b000);
      chk("up_510_carry", 0, 0, 0, 0, 1, 12'h510, 3'b001);
      chk("down_509_carry", 0, 0, 0, 1, 1, 12'h509, 3'b001);
      chk("clear_over_pulse", 0, 1, 0, 0, 1, 12'h000, 3'b000);
      chk("down_from_0", 0, 0, 0, 1, 1, 12'h999, 3'b111);
      chk("clear_kills_carry", 0, 1, 1, 0, 1, 12'h000, 3'b000);

`ifdef PULSE_DIV_LOAD_EN
      step("load_clamp", 0, 0, 0, 0, 0, 1, {4'd15, 4'd3, 4'd7}, 1, 12'h937, 3'b000);
      chk("load_then_up", 0, 0, 0, 0, 1, 12'h938, 3'b000);
      step("load_over_pulse", 0, 0, 0, 0, 1, 1, {4'd2, 4'd9, 4'd9}, 1, 12'h299, 3'b000);
      chk("load_ripple", 0, 0, 0, 0, 1, 12'h300, 3'b011);
      step("clear_over_load", 0, 1, 0, 0, 1, 1, 12'h555, 1, 12'h000, 3'b000);
      step("load_over_pause", 0, 0, 1, 0, 0, 1, {4'd12, 4'd10, 4'd0}, 1, 12'h990, 3'b000);
`endif

      chk("pulse_before_rst", 0, 0, 0, 0, 1, to_bcd(m_v + 1), 3'b000);
      chk("rst_over_clear", 1, 1, 0, 1, 1, 12'h000, 3'b000);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         misc++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
      $finish;
   end
endmodule
